nios2_oci_dct_capture: RTL and testbench



---
 rtl/nios2_oci_dct_capture_if.sv | 23 ++
 rtl/nios2_oci_dct_capture.sv | 126 ++++++++++++
 tb/tb_nios2_oci_dct_capture.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_oci_dct_capture_if.sv
// Trace-frame producer and FIFO-head consumer signals of the DCT capture block.
interface nios2_oci_dct_capture_if #(
  parameter int SLOT_W = 2,
  parameter int SLOTS  = 15,
  parameter int CNT_W  = 4
);
  logic [SLOTS*SLOT_W-1:0]       dct_buffer;
  logic [CNT_W-1:0]              dct_count;
  logic                          dct_valid;
  logic [CNT_W+SLOTS*SLOT_W-1:0] out_data;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output dct_buffer, dct_count, dct_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  dct_buffer, dct_count, dct_valid, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/nios2_oci_dct_capture.sv
// Captures DCT trace frames into a show-ahead FIFO: 1-cycle push-to-head latency.
// A full FIFO drops and counts frames unless a pop frees a slot on the same edge.
module nios2_oci_dct_capture #(
  parameter int SLOT_W = 2,
  parameter int SLOTS  = 15,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int OVF_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  nios2_oci_dct_capture_if.slave    dct,
  input  logic                      test_ending,
  input  logic                      test_has_ended,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic [OVF_W-1:0]          overflow_cnt,
  output logic                      range_err,
  output logic                      capture_done
);
  localparam int BUF_W  = SLOTS * SLOT_W;
  localparam int DATA_W = CNT_W + BUF_W;
  localparam int AW     = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  cnt_clamped;
  logic [BUF_W-1:0]  buf_masked;
  logic              over_range;
  logic              frame_req;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  assign over_range  = dct.dct_count > CNT_W'(SLOTS);
  assign cnt_clamped = over_range ? CNT_W'(SLOTS) : dct.dct_count;

  // Slots beyond the valid count are zeroed so stale buffer bits never reach the consumer.
  always_comb begin
    buf_masked = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (CNT_W'(i) < cnt_clamped) begin
        buf_masked[i*SLOT_W +: SLOT_W] = dct.dct_buffer[i*SLOT_W +: SLOT_W];
      end
    end
  end

  assign empty     = (fill_level == '0);
  assign full      = (fill_level == (AW+1)'(DEPTH));
  assign frame_req = (state == RUN) && dct.dct_valid && (dct.dct_count != '0);
  assign pop       = dct.out_valid && dct.out_ready;
  assign push      = frame_req && (!full || pop);
  assign drop      = frame_req && full && !pop;

  assign dct.out_valid = !empty;
  assign dct.out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cnt_clamped, buf_masked};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      overflow_cnt <= '0;
      range_err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        fill_level <= fill_level + (AW+1)'(1);
      end else if (pop && !push) begin
        fill_level <= fill_level - (AW+1)'(1);
      end
      if (drop && (overflow_cnt != '1)) begin
        overflow_cnt <= overflow_cnt + OVF_W'(1);
      end
      if (frame_req && over_range) begin
        range_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      capture_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (test_ending) begin
            if (test_has_ended && empty) begin
              state        <= DONE;
              capture_done <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (empty && test_has_ended) begin
            state        <= DONE;
            capture_done <= 1'b1;
          end
        end
        DONE: begin
          state        <= DONE;
          capture_done <= 1'b1;
        end
        default: begin
          state        <= RUN;
          capture_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Self-checking bench: vector table, hand-written corner sequences, and random traffic against a queue model.
module tb_nios2_oci_dct_capture;
  localparam int SLOT_W = 2;
  localparam int SLOTS  = 15;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 16;
  localparam int OVF_W  = 16;
  localparam int BW     = SLOTS * SLOT_W;
  localparam int DW     = CNT_W + BW;

  logic        clk = 1'b0;
  logic        reset;
  logic        test_ending;
  logic        test_has_ended;
  logic [4:0]  fill_level;
  logic [15:0] overflow_cnt;
  logic        range_err;
  logic        capture_done;
  logic [4:0]  fill_r;
  logic [15:0] ovf_r;
  logic        rerr_r;
  logic        done_r;

  always #5 clk = ~clk;

  nios2_oci_dct_capture_if #(.SLOT_W(SLOT_W), .SLOTS(SLOTS), .CNT_W(CNT_W)) bus ();
  nios2_oci_dct_capture_if #(.SLOT_W(2), .SLOTS(13), .CNT_W(4)) busr ();

  nios2_oci_dct_capture #(
    .SLOT_W(SLOT_W), .SLOTS(SLOTS), .CNT_W(CNT_W), .DEPTH(DEPTH), .OVF_W(OVF_W)
  ) dut (
    .clk(clk), .reset(reset), .dct(bus),
    .test_ending(test_ending), .test_has_ended(test_has_ended),
    .fill_level(fill_level), .overflow_cnt(overflow_cnt),
    .range_err(range_err), .capture_done(capture_done)
  );

  // Narrower instance so that a count above SLOTS is representable.
  nios2_oci_dct_capture #(
    .SLOT_W(2), .SLOTS(13), .CNT_W(4), .DEPTH(16), .OVF_W(16)
  ) dut_r (
    .clk(clk), .reset(reset), .dct(busr),
    .test_ending(1'b0), .test_has_ended(1'b0),
    .fill_level(fill_r), .overflow_cnt(ovf_r),
    .range_err(rerr_r), .capture_done(done_r)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] q[$];
  int m_ovf;
  bit m_rng;

  typedef struct {
    bit            v;
    int            c;
    logic [BW-1:0] b;
    bit            r;
    bit            ev;
    int            ef;
    logic [DW-1:0] ed;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected stored word: count clamped to SLOTS, everything above count*SLOT_W bits cleared.
  function automatic logic [DW-1:0] fmt(input int c, input logic [BW-1:0] b);
    int k;
    logic [63:0] m;
    k = (c > SLOTS) ? SLOTS : c;
    m = (64'd1 << (SLOT_W * k)) - 64'd1;
    return {CNT_W'(k), BW'(64'(b) & m)};
  endfunction

  task automatic drive(input bit v, input int c, input logic [BW-1:0] b, input bit r);
    bus.dct_valid  = v;
    bus.dct_count  = CNT_W'(c);
    bus.dct_buffer = b;
    bus.out_ready  = r;
  endtask

  task automatic drive_r(input bit v, input int c, input logic [25:0] b, input bit r);
    busr.dct_valid  = v;
    busr.dct_count  = 4'(c);
    busr.dct_buffer = b;
    busr.out_ready  = r;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 0, '0, 1'b0);
    drive_r(1'b0, 0, '0, 1'b0);
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    reset          = 1'b1;
    q.delete();
    m_ovf = 0;
    m_rng = 1'b0;
    edge_wait();
    reset = 1'b0;
  endtask

  // One cycle in capture mode, checked against the queue model.
  task automatic mstep(input bit v, input int c, input logic [BW-1:0] b, input bit r);
    bit pop;
    bit req;
    drive(v, c, b, r);
    pop = (q.size() > 0) && r;
    req = v && (c != 0);
    if (req && c > SLOTS) m_rng = 1'b1;
    if (pop) void'(q.pop_front());
    if (req) begin
      if (q.size() < DEPTH) q.push_back(fmt(c, b));
      else if (m_ovf < 65535) m_ovf++;
    end
    edge_wait();
    chk("m_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("m_fill", 64'(fill_level), 64'(q.size()));
    if (q.size() != 0) chk("m_data", 64'(bus.out_data), 64'(q[0]));
    chk("m_ovf", 64'(overflow_cnt), 64'(m_ovf));
    chk("m_rerr", 64'(range_err), 64'(m_rng));
  endtask

  initial begin
    tbl[0] = '{1'b1, 3,  30'h3FFFFFFF, 1'b0, 1'b1, 1, {4'd3,  30'h0000003F}};
    tbl[1] = '{1'b1, 0,  30'h3FFFFFFF, 1'b0, 1'b1, 1, {4'd3,  30'h0000003F}};
    tbl[2] = '{1'b1, 15, 30'h2AAAAAAA, 1'b0, 1'b1, 2, {4'd3,  30'h0000003F}};
    tbl[3] = '{1'b0, 0,  30'h00000000, 1'b1, 1'b1, 1, {4'd15, 30'h2AAAAAAA}};
    tbl[4] = '{1'b1, 1,  30'h3FFFFFFF, 1'b1, 1'b1, 1, {4'd1,  30'h00000003}};
    tbl[5] = '{1'b1, 7,  30'h12345678, 1'b0, 1'b1, 2, {4'd1,  30'h00000003}};
    tbl[6] = '{1'b0, 0,  30'h00000000, 1'b1, 1'b1, 1, {4'd7,  30'h00001678}};
    tbl[7] = '{1'b0, 0,  30'h00000000, 1'b1, 1'b0, 0, '0};

    // Reset state
    drive(1'b0, 0, '0, 1'b0);
    drive_r(1'b0, 0, '0, 1'b0);
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    reset          = 1'b1;
    #12;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_ovf", 64'(overflow_cnt), 64'd0);
    chk("rst_rerr", 64'(range_err), 64'd0);
    chk("rst_done", 64'(capture_done), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Out-of-range count on the 13-slot instance: clamped and sticky
    drive_r(1'b1, 15, 26'h3FFFFFF, 1'b0);
    edge_wait();
    chk("r_rerr_set", 64'(rerr_r), 64'd1);
    chk("r_fill", 64'(fill_r), 64'd1);
    chk("r_clamp", 64'(busr.out_data), 64'({4'd13, 26'h3FFFFFF}));
    drive_r(1'b1, 0, 26'h3FFFFFF, 1'b0);
    edge_wait();
    chk("r_zero_cnt", 64'(fill_r), 64'd1);
    drive_r(1'b1, 2, 26'h3FFFFFF, 1'b1);
    edge_wait();
    chk("r_sticky", 64'(rerr_r), 64'd1);
    chk("r_head", 64'(busr.out_data), 64'({4'd2, 26'h000000F}));
    drive_r(1'b0, 0, '0, 1'b0);

    // Vector table on the main instance
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].b, tbl[i].r);
      edge_wait();
      chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_fill", i), 64'(fill_level), 64'(tbl[i].ef));
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), 64'(bus.out_data), 64'(tbl[i].ed));
      chk($sformatf("vec%0d_rerr", i), 64'(range_err), 64'd0);
      chk($sformatf("vec%0d_ovf", i), 64'(overflow_cnt), 64'd0);
    end

    // Overflow, then full with simultaneous push and pop, then in-order drain
    do_reset();
    chk("rst_clears_rerr", 64'(rerr_r), 64'd0);
    for (int i = 0; i < 20; i++) mstep(1'b1, (i % 15) + 1, BW'(32'h0ABCDEF1 * (i + 1)), 1'b0);
    chk("full_fill", 64'(fill_level), 64'd16);
    chk("full_ovf", 64'(overflow_cnt), 64'd4);
    chk("full_head", 64'(bus.out_data), 64'(fmt(1, BW'(32'h0ABCDEF1))));
    mstep(1'b1, 5, 30'h155, 1'b1);
    chk("pp_fill", 64'(fill_level), 64'd16);
    chk("pp_ovf", 64'(overflow_cnt), 64'd4);
    for (int i = 0; i < 16; i++) mstep(1'b0, 0, '0, 1'b1);

    // Drain: five queued entries, then DONE; pushes during drain are ignored
    do_reset();
    for (int i = 0; i < 5; i++) mstep(1'b1, i + 1, 30'h3FFFFFFF, 1'b0);
    test_ending    = 1'b1;
    test_has_ended = 1'b1;
    drive(1'b0, 0, '0, 1'b1);
    edge_wait();
    chk("drain0_done", 64'(capture_done), 64'd0);
    chk("drain0_fill", 64'(fill_level), 64'd4);
    for (int k = 1; k < 5; k++) begin
      drive(1'b1, 3, 30'h3F, 1'b1);
      edge_wait();
      chk($sformatf("drain%0d_done", k), 64'(capture_done), 64'd0);
      chk($sformatf("drain%0d_fill", k), 64'(fill_level), 64'(4 - k));
    end
    edge_wait();
    chk("done_set", 64'(capture_done), 64'd1);
    chk("done_valid", 64'(bus.out_valid), 64'd0);
    edge_wait();
    chk("done_hold", 64'(capture_done), 64'd1);
    chk("done_nopush", 64'(fill_level), 64'd0);
    chk("done_ovf", 64'(overflow_cnt), 64'd0);

    // Frame on the first test_ending cycle is kept; later ones are not
    do_reset();
    test_ending = 1'b1;
    drive(1'b1, 2, 30'h0000000F, 1'b0);
    edge_wait();
    chk("te_push_fill", 64'(fill_level), 64'd1);
    chk("te_push_data", 64'(bus.out_data), 64'({4'd2, 30'h0000000F}));
    edge_wait();
    chk("te_ignored", 64'(fill_level), 64'd1);
    test_has_ended = 1'b1;
    drive(1'b0, 0, '0, 1'b1);
    edge_wait();
    chk("te_pop_done", 64'(capture_done), 64'd0);
    chk("te_pop_fill", 64'(fill_level), 64'd0);
    edge_wait();
    chk("te_done", 64'(capture_done), 64'd1);

    // Straight from capture to done when already empty and ended
    do_reset();
    test_ending    = 1'b1;
    test_has_ended = 1'b1;
    edge_wait();
    chk("direct_done", 64'(capture_done), 64'd1);

    // Asynchronous reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 8; i++) mstep(1'b1, 4, BW'(32'h11111111 * (i + 1)), 1'b0);
    test_ending = 1'b1;
    drive(1'b0, 0, '0, 1'b1);
    edge_wait();
    edge_wait();
    chk("mid_fill", 64'(fill_level), 64'd6);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_fill", 64'(fill_level), 64'd0);
    edge_wait();
    reset       = 1'b0;
    test_ending = 1'b0;
    chk("post_valid", 64'(bus.out_valid), 64'd0);
    chk("post_fill", 64'(fill_level), 64'd0);
    chk("post_done", 64'(capture_done), 64'd0);
    drive(1'b1, 4, 30'h000000FF, 1'b0);
    edge_wait();
    chk("first_push_fill", 64'(fill_level), 64'd1);
    chk("first_push_data", 64'(bus.out_data), 64'({4'd4, 30'h000000FF}));

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 800; k++) begin
      mstep(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), BW'($urandom),
            ($urandom_range(0, 99) < ((k < 400) ? 30 : 70)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
